rand_arbiter: RTL and testbench
===============================

Name: rand_arbiter

Overview:
- Shares one 8-bit LFSR random source between N_REQ requesters using round-robin arbitration and a req/gnt handshake.
- Each grant advances the LFSR by exactly one step, and the winning requester receives the new value.
- Provides a seed-load path so software/top-level can reseed the source.
- Sits between the game/control FSMs that consume random bytes and the random generator core.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SEED, 8'h01, LFSR value after reset; also substituted whenever a zero seed is loaded.
- ID_W, $clog2(N_REQ), localparam, width of rid.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester; held until its gnt bit is seen.
- seed_we  in  1  one-cycle pulse: load seed_data into the LFSR.
- seed_data  in  8  new seed value.
- gnt  out  N_REQ  one-hot grant, valid for exactly one cycle.
- rvalid  out  1  rdata/rid valid, coincident with gnt.
- rdata  out  8  random byte delivered to the winner.
- rid  out  ID_W  index of the winner.
- busy  out  1  high while in RESP.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, LFSR=SEED, round-robin pointer=0.
  - gnt=0, rvalid=0, rdata=8'h00, rid=0, busy=0.
  - All take effect immediately, including mid-RESP.
- LFSR step (Fibonacci):
  - fb = q[7]^q[5]^q[4]^q[3]; q_next = {q[6:0], fb}.
  - The all-zero state is unreachable.
- FSM has 2 states, IDLE and RESP.
- IDLE:
  - If seed_we: LFSR = (seed_data==0) ? SEED : seed_data. No grant this edge; stay IDLE. Seed has priority over req.
  - Else if req != 0:
    - Winner = first set bit of req searching upward from pointer, wrapping modulo N_REQ.
    - LFSR steps.
    - Registered outputs: gnt=onehot(winner), rvalid=1, rdata=stepped LFSR value, rid=winner, busy=1.
    - pointer = (winner+1) mod N_REQ; go to RESP.
  - Else hold all state; outputs 0.
- RESP (exactly one cycle):
  - Next edge clears gnt, rvalid and busy; go to IDLE. rdata/rid hold their last value.
  - req is ignored in RESP.
  - seed_we in RESP still loads the LFSR (zero→SEED rule applies); it does not alter the value already delivered.
- Latency and throughput:
  - A request sampled at edge E in IDLE is answered in the cycle after E.
  - Maximum throughput is one grant per 2 cycles.
  - A requester must drop req by the edge after it sees gnt; the RESP cycle guarantees it is not re-granted.
- No LFSR stepping when idle (no free-run).
- A req bit that drops before being granted is simply never served; no state is kept per requester.

Decomposition:
- Shared package rand_pkg holds:
  - LFSR width (8) and tap constants (7,5,4,3);
  - DEFAULT_SEED = 8'h01;
  - state enum {IDLE, RESP}.
- Sub-module lfsr8_core: clock, reset, load, load_val, step → q[7:0].
  - Implements the step rule and the zero→SEED substitution.
  - Reused by other random-consuming blocks.
- The arbiter FSM and round-robin pointer stay in rand_arbiter.

Test Plan:
- Release reset, req=4'b0001 held → one cycle after first sampling edge: gnt=4'b0001, rvalid=1, rid=0, rdata=8'h02; rvalid low next cycle.
- From reset, req=4'b1111 held → grants every 2 cycles to rid 0,1,2,3,0 with rdata 8'h02, 8'h04, 8'h08, 8'h11, 8'h23.
- seed_we with seed_data=8'hA5, then req=4'b0100 → gnt=4'b0100, rid=2, rdata=8'h4A. seed_we with seed_data=8'h00, then a request → rdata=8'h02 (SEED applied).
- seed_we and req=4'b0010 on the same IDLE edge → no gnt that cycle; seed loaded. The grant follows on the next edge with rdata = step(seed).
- After grant to rid 0 (pointer=1), apply req=4'b1001 → rid=3 granted before rid 0. Next grant goes to rid 0.
- Assert reset during the RESP cycle → gnt/rvalid/busy drop asynchronously. After release with req=4'b0001, rdata=8'h02 and rid=0 (LFSR and pointer restored).

Source files
------------

// File: rtl/rand_pkg.sv
// Shared constants, state type and step function for the 8-bit random source.
package rand_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned TAP_A  = 7;
  localparam int unsigned TAP_B  = 5;
  localparam int unsigned TAP_C  = 4;
  localparam int unsigned TAP_D  = 3;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // One Fibonacci step: shift left, feedback is the XOR of the four taps.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    logic fb;
    fb = q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];
    return {q[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/rand_arbiter_if.sv
// Request/grant and seed-load bundle between random consumers and the arbiter.
interface rand_arbiter_if
  import rand_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]  req;
  logic              seed_we;
  logic [LFSR_W-1:0] seed_data;
  logic [N_REQ-1:0]  gnt;
  logic              rvalid;
  logic [LFSR_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic              busy;

  modport master (
    output req, seed_we, seed_data,
    input  gnt, rvalid, rdata, rid, busy
  );

  modport slave (
    input  req, seed_we, seed_data,
    output gnt, rvalid, rdata, rid, busy
  );

endinterface

// File: rtl/lfsr8_core.sv
// 8-bit Fibonacci LFSR with load; a zero load value falls back to SEED.
module lfsr8_core
  import rand_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  // Load wins over step so a reseed never gets lost under traffic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else if (load) begin
      q <= (load_val == '0) ? SEED : load_val;
    end else if (step) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing one fresh LFSR byte to one requester per grant.
module rand_arbiter
  import rand_pkg::*;
#(
  parameter int unsigned       N_REQ = 4,
  parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic          clock,
  input  logic          reset,
  rand_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  state_e            state, state_d;
  logic [ID_W-1:0]   ptr, ptr_d;
  logic [ID_W-1:0]   idx, winner;
  logic              found;
  logic              step_en;
  logic [LFSR_W-1:0] lfsr_q;

  logic [N_REQ-1:0]  gnt, gnt_d;
  logic              rvalid, rvalid_d;
  logic              busy, busy_d;
  logic [LFSR_W-1:0] rdata, rdata_d;
  logic [ID_W-1:0]   rid, rid_d;

  lfsr8_core #(.SEED(SEED)) u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .load     (bus.seed_we),
    .load_val (bus.seed_data),
    .step     (step_en),
    .q        (lfsr_q)
  );

  // First set request bit at or above ptr, wrapping past the last requester.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == LAST_ID) ? '0 : idx + ID_W'(1);
    end
  end

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    gnt_d    = '0;
    rvalid_d = 1'b0;
    busy_d   = 1'b0;
    rdata_d  = rdata;
    rid_d    = rid;
    step_en  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.seed_we && found) begin
          step_en  = 1'b1;
          gnt_d    = N_REQ'(1) << winner;
          rvalid_d = 1'b1;
          busy_d   = 1'b1;
          rdata_d  = lfsr_step(lfsr_q);
          rid_d    = winner;
          ptr_d    = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
          state_d  = RESP;
        end
      end
      RESP: begin
        // Requests are ignored here so the last winner cannot be re-granted.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      rvalid <= 1'b0;
      busy   <= 1'b0;
      rdata  <= '0;
      rid    <= '0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      gnt    <= gnt_d;
      rvalid <= rvalid_d;
      busy   <= busy_d;
      rdata  <= rdata_d;
      rid    <= rid_d;
    end
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rvalid;
  assign bus.busy   = busy;
  assign bus.rdata  = rdata;
  assign bus.rid    = rid;

endmodule

// File: tb/tb_rand_arbiter.sv
// Scoreboard bench for rand_arbiter: driver predicts grants, monitor checks them.
module tb_rand_arbiter;

  localparam int unsigned N = 4;
  localparam logic [7:0]  SEED_C = 8'h01;

  typedef struct {
    int unsigned due;
    logic [3:0]  gnt;
    int unsigned rid;
    logic [7:0]  rdata;
  } exp_t;

  logic clock;
  logic reset;

  rand_arbiter_if #(.N_REQ(N)) bus ();

  rand_arbiter #(.N_REQ(N), .SEED(SEED_C)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        q[$];
  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_bad;

  logic [7:0]  m_lfsr;
  int unsigned m_ptr;
  bit          m_busy;

  logic [7:0]  last_rdata;
  int unsigned last_rid;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: taps 7,5,4,3 form mask 0xB8; feedback is the parity of the masked value.
  function automatic logic [7:0] ref_step(input logic [7:0] v);
    logic [7:0] t;
    t = v & 8'hB8;
    return {v[6:0], ^t};
  endfunction

  // Model of what the next rising edge does with the given inputs.
  function automatic void predict(input logic [3:0] r, input logic sw, input logic [7:0] sd);
    int unsigned w;
    if (sw) m_lfsr = (sd == 8'h00) ? SEED_C : sd;
    if (m_busy) begin
      m_busy = 1'b0;
    end else if (!sw && r != 4'h0) begin
      w = m_ptr;
      while (r[2'(w)] == 1'b0) w = (w + 1) % N;
      m_lfsr = ref_step(m_lfsr);
      q.push_back('{due: cyc + 1, gnt: 4'(1 << w), rid: w, rdata: m_lfsr});
      m_ptr  = (w + 1) % N;
      m_busy = 1'b1;
    end
  endfunction

  task automatic drive(input logic [3:0] r, input logic sw, input logic [7:0] sd);
    @(negedge clock);
    bus.req       = r;
    bus.seed_we   = sw;
    bus.seed_data = sd;
    predict(r, sw, sd);
    @(posedge clock);
  endtask

  // Asserts reset just after a rising edge, releases on the next falling edge.
  task automatic hard_reset();
    #1;
    reset         = 1'b0;
    bus.req       = '0;
    bus.seed_we   = 1'b0;
    bus.seed_data = '0;
    m_lfsr        = SEED_C;
    m_ptr         = 0;
    m_busy        = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
  endtask

  // Monitor: checks outputs on falling edges and immediately after reset asserts.
  initial begin
    exp_t e;
    last_rdata = 8'h00;
    last_rid   = 0;
    forever begin
      @(negedge clock or negedge reset);
      if (!reset) begin
        #1;
        chk("rst_gnt",    32'(bus.gnt),    32'h0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rst_busy",   32'(bus.busy),   32'h0);
        chk("rst_rdata",  32'(bus.rdata),  32'h0);
        chk("rst_rid",    32'(bus.rid),    32'h0);
        q.delete();
        last_rdata = 8'h00;
        last_rid   = 0;
      end else if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("gnt",    32'(bus.gnt),    32'(e.gnt));
        chk("rvalid", 32'(bus.rvalid), 32'h1);
        chk("busy",   32'(bus.busy),   32'h1);
        chk("rid",    32'(bus.rid),    e.rid);
        chk("rdata",  32'(bus.rdata),  32'(e.rdata));
        last_rdata = e.rdata;
        last_rid   = e.rid;
      end else begin
        chk("idle_gnt",    32'(bus.gnt),    32'h0);
        chk("idle_rvalid", 32'(bus.rvalid), 32'h0);
        chk("idle_busy",   32'(bus.busy),   32'h0);
        chk("hold_rdata",  32'(bus.rdata),  32'(last_rdata));
        chk("hold_rid",    32'(bus.rid),    last_rid);
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       sw;
    logic [7:0] sd;
    reset         = 1'b0;
    bus.req       = '0;
    bus.seed_we   = 1'b0;
    bus.seed_data = '0;
    m_lfsr        = SEED_C;
    m_ptr         = 0;
    m_busy        = 1'b0;
    repeat (2) @(posedge clock);
    hard_reset();

    // Single requester from reset.
    drive(4'b0001, 1'b0, 8'h00);
    drive(4'b0000, 1'b0, 8'h00);
    drive(4'b0000, 1'b0, 8'h00);

    // All requesting from reset: rotation through 0,1,2,3,0.
    hard_reset();
    repeat (10) drive(4'b1111, 1'b0, 8'h00);
    drive(4'b0000, 1'b0, 8'h00);

    // Reseed with A5, then a request; reseed with zero, then a request.
    drive(4'b0000, 1'b1, 8'hA5);
    drive(4'b0100, 1'b0, 8'h00);
    drive(4'b0000, 1'b0, 8'h00);
    drive(4'b0000, 1'b1, 8'h00);
    drive(4'b0001, 1'b0, 8'h00);
    drive(4'b0000, 1'b0, 8'h00);

    // Seed and request on the same edge: seed wins, grant follows.
    drive(4'b0010, 1'b1, 8'h33);
    drive(4'b0010, 1'b0, 8'h00);
    drive(4'b0000, 1'b1, 8'h5C);
    drive(4'b0001, 1'b0, 8'h00);
    drive(4'b0000, 1'b0, 8'h00);

    // Pointer after rid 0 favours rid 3 over rid 0.
    hard_reset();
    drive(4'b0001, 1'b0, 8'h00);
    drive(4'b1001, 1'b0, 8'h00);
    drive(4'b1001, 1'b0, 8'h00);
    drive(4'b1001, 1'b0, 8'h00);
    drive(4'b1001, 1'b0, 8'h00);
    drive(4'b0000, 1'b0, 8'h00);

    // Reset during RESP, then recovery.
    drive(4'b0110, 1'b0, 8'h00);
    hard_reset();
    drive(4'b0001, 1'b0, 8'h00);
    drive(4'b0000, 1'b0, 8'h00);

    // Randomized traffic with occasional reseeds, including zero seeds.
    for (int n = 0; n < 400; n++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'h0;
      sw = ($urandom_range(0, 7) == 0);
      sd = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      drive(r, sw, sd);
    end
    repeat (3) drive(4'b0000, 1'b0, 8'h00);

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
